// File: rtl/rc4_pkg.sv
// -----------------------------------------------------------------------------
// rc4_pkg
// Shared types and constants for the RC4 keystream/decrypt engine.
//   rc4_prga_state_t : FSM state encoding of rc4_prga_decoder
//   RC4_CHAR_LO/HI   : inclusive range of accepted plaintext letters ('a'..'z')
//   RC4_CHAR_SPACE   : the only other accepted plaintext character (' ')
//   RC4_S_DEPTH      : number of entries in the RC4 S array
//   rc4_state_busy() : true for every state that is part of a byte's processing
// -----------------------------------------------------------------------------
package rc4_pkg;

  typedef enum logic [3:0] {
    ST_IDLE = 4'd0,
    ST_RD_I = 4'd1,
    ST_WT_I = 4'd2,
    ST_RD_J = 4'd3,
    ST_WT_J = 4'd4,
    ST_WR_I = 4'd5,
    ST_WR_J = 4'd6,
    ST_RD_F = 4'd7,
    ST_WT_F = 4'd8,
    ST_WR_O = 4'd9,
    ST_NEXT = 4'd10,
    ST_DONE = 4'd11
  } rc4_prga_state_t;

  localparam logic [7:0] RC4_CHAR_LO    = 8'h61;
  localparam logic [7:0] RC4_CHAR_HI    = 8'h7A;
  localparam logic [7:0] RC4_CHAR_SPACE = 8'h20;
  localparam int         RC4_S_DEPTH    = 256;

  // Busy covers the whole per-byte sequence, i.e. everything but IDLE and DONE.
  function automatic logic rc4_state_busy(input rc4_prga_state_t st);
    logic busy_v;
    case (st)
      ST_IDLE: busy_v = 1'b0;
      ST_DONE: busy_v = 1'b0;
      default: busy_v = 1'b1;
    endcase
    return busy_v;
  endfunction

endpackage

// File: rtl/rc4_char_check.sv
// -----------------------------------------------------------------------------
// rc4_char_check
// Combinational plaintext character filter used for early abort during a
// brute-force key search: a byte is acceptable when it is a lowercase letter
// or a space.
// Ports:
//   char_byte : in  8  candidate plaintext byte
//   valid     : out 1  1 when char_byte is in 'a'..'z' or equals ' '
// -----------------------------------------------------------------------------
module rc4_char_check
  import rc4_pkg::*;
(
  input  logic [7:0] char_byte,
  output logic       valid
);

  logic in_range_s;
  logic is_space_s;

  // Range and space tests, kept separate for readability.
  always_comb begin
    in_range_s = (char_byte >= RC4_CHAR_LO) && (char_byte <= RC4_CHAR_HI);
    is_space_s = (char_byte == RC4_CHAR_SPACE);
    valid      = in_range_s || is_space_s;
  end

endmodule

// File: rtl/rc4_prga_decoder.sv
// -----------------------------------------------------------------------------
// rc4_prga_decoder
// RC4 PRGA keystream generator and decryptor. Runs after S initialisation and
// key scheduling and owns the S memory port while busy. For each of MSG_LEN
// ciphertext bytes it performs the PRGA swap, fetches the keystream byte,
// XORs it with the ciphertext byte and writes the plaintext byte. Each byte
// takes 10 cycles; all memory interface outputs are decoded from the state
// and internal registers only (no input-to-output combinational path).
//
// Optional feature (compile-time macro RC4_PRGA_VALID_CHECK_EN): every written
// plaintext byte is checked by rc4_char_check; the first invalid byte is still
// written, then the run ends in DONE with bad_key=1. Without the macro all
// bytes are processed and bad_key is constant 0.
//
// Parameters:
//   MSG_LEN : number of message bytes (1..256)
//   ADDR_W  : width of encrypted/decrypted memory addresses
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   start               : level run request, only sampled in IDLE
//   s_mem_addr/data/wren, s_mem_q : S memory (registered read, 1-cycle latency)
//   encr_mem_addr, encr_mem_q     : ciphertext ROM (registered read)
//   decr_mem_addr/data/wren       : plaintext RAM write port
//   busy    : high while processing (not IDLE, not DONE)
//   done    : high while in DONE
//   bad_key : high in DONE when the run aborted on an invalid character
// -----------------------------------------------------------------------------
module rc4_prga_decoder
  import rc4_pkg::*;
#(
  parameter int MSG_LEN = 32,
  parameter int ADDR_W  = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [7:0]        s_mem_addr,
  output logic [7:0]        s_mem_data,
  output logic              s_mem_wren,
  input  logic [7:0]        s_mem_q,
  output logic [ADDR_W-1:0] encr_mem_addr,
  input  logic [7:0]        encr_mem_q,
  output logic [ADDR_W-1:0] decr_mem_addr,
  output logic [7:0]        decr_mem_data,
  output logic              decr_mem_wren,
  output logic              busy,
  output logic              done,
  output logic              bad_key
);

  localparam logic [ADDR_W-1:0] K_LAST = ADDR_W'(MSG_LEN - 1);

  rc4_prga_state_t   state_r;
  rc4_prga_state_t   state_nxt_s;
  logic [7:0]        i_r,   i_nxt_s;
  logic [7:0]        j_r,   j_nxt_s;
  logic [ADDR_W-1:0] k_r,   k_nxt_s;
  logic [7:0]        si_r,  si_nxt_s;
  logic [7:0]        sj_r,  sj_nxt_s;
  logic [7:0]        f_r,   f_nxt_s;
  logic [7:0]        enc_r, enc_nxt_s;
  logic [7:0]        plain_s;

  assign plain_s = f_r ^ enc_r;

`ifdef RC4_PRGA_VALID_CHECK_EN
  logic char_ok_s;
  logic bad_key_r;
  logic bad_nxt_s;

  rc4_char_check u_char_check (
    .char_byte (plain_s),
    .valid     (char_ok_s)
  );

  // Abort flag: cleared when a run is accepted, set on the first invalid byte.
  always_comb begin
    bad_nxt_s = bad_key_r;
    if ((state_r == ST_IDLE) && start) begin
      bad_nxt_s = 1'b0;
    end else if ((state_r == ST_WR_O) && !char_ok_s) begin
      bad_nxt_s = 1'b1;
    end else begin
      bad_nxt_s = bad_key_r;
    end
  end

  // Abort flag register.
  always_ff @(posedge clk) begin
    if (reset) begin
      bad_key_r <= 1'b0;
    end else begin
      bad_key_r <= bad_nxt_s;
    end
  end

  assign bad_key = bad_key_r;
`else
  assign bad_key = 1'b0;
`endif

  // Next-state and datapath register update logic.
  always_comb begin
    state_nxt_s = state_r;
    i_nxt_s     = i_r;
    j_nxt_s     = j_r;
    k_nxt_s     = k_r;
    si_nxt_s    = si_r;
    sj_nxt_s    = sj_r;
    f_nxt_s     = f_r;
    enc_nxt_s   = enc_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          i_nxt_s     = 8'd1;
          j_nxt_s     = 8'd0;
          k_nxt_s     = '0;
          state_nxt_s = ST_RD_I;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RD_I: state_nxt_s = ST_WT_I;
      ST_WT_I: begin
        si_nxt_s    = s_mem_q;
        j_nxt_s     = j_r + s_mem_q;
        state_nxt_s = ST_RD_J;
      end
      ST_RD_J: state_nxt_s = ST_WT_J;
      ST_WT_J: begin
        sj_nxt_s    = s_mem_q;
        state_nxt_s = ST_WR_I;
      end
      ST_WR_I: state_nxt_s = ST_WR_J;
      ST_WR_J: state_nxt_s = ST_RD_F;
      ST_RD_F: state_nxt_s = ST_WT_F;
      ST_WT_F: begin
        f_nxt_s     = s_mem_q;
        enc_nxt_s   = encr_mem_q;
        state_nxt_s = ST_WR_O;
      end
      ST_WR_O: begin
`ifdef RC4_PRGA_VALID_CHECK_EN
        // An invalid byte is still written this cycle; the run then ends.
        if (char_ok_s) begin
          state_nxt_s = ST_NEXT;
        end else begin
          state_nxt_s = ST_DONE;
        end
`else
        state_nxt_s = ST_NEXT;
`endif
      end
      ST_NEXT: begin
        if (k_r == K_LAST) begin
          state_nxt_s = ST_DONE;
        end else begin
          k_nxt_s     = k_r + ADDR_W'(1);
          i_nxt_s     = i_r + 8'd1;
          state_nxt_s = ST_RD_I;
        end
      end
      ST_DONE: begin
        // A start level held from the previous run must drop before a new run.
        if (start) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset returns everything to zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
      i_r     <= 8'd0;
      j_r     <= 8'd0;
      k_r     <= '0;
      si_r    <= 8'd0;
      sj_r    <= 8'd0;
      f_r     <= 8'd0;
      enc_r   <= 8'd0;
    end else begin
      state_r <= state_nxt_s;
      i_r     <= i_nxt_s;
      j_r     <= j_nxt_s;
      k_r     <= k_nxt_s;
      si_r    <= si_nxt_s;
      sj_r    <= sj_nxt_s;
      f_r     <= f_nxt_s;
      enc_r   <= enc_nxt_s;
    end
  end

  // Moore decode of the memory ports; idle values are all zero.
  always_comb begin
    s_mem_addr    = 8'd0;
    s_mem_data    = 8'd0;
    s_mem_wren    = 1'b0;
    encr_mem_addr = '0;
    decr_mem_addr = '0;
    decr_mem_data = 8'd0;
    decr_mem_wren = 1'b0;
    case (state_r)
      ST_RD_I: s_mem_addr = i_r;
      ST_RD_J: s_mem_addr = j_r;
      ST_WR_I: begin
        s_mem_addr = i_r;
        s_mem_data = sj_r;
        s_mem_wren = 1'b1;
      end
      ST_WR_J: begin
        // When i == j this rewrites the same entry with the same value.
        s_mem_addr = j_r;
        s_mem_data = si_r;
        s_mem_wren = 1'b1;
      end
      ST_RD_F: begin
        s_mem_addr    = si_r + sj_r;
        encr_mem_addr = k_r;
      end
      ST_WR_O: begin
        decr_mem_addr = k_r;
        decr_mem_data = plain_s;
        decr_mem_wren = 1'b1;
      end
      default: begin
        s_mem_addr = 8'd0;
      end
    endcase
  end

  // Status flags decoded from the state register.
  always_comb begin
    busy = rc4_state_busy(state_r);
    done = (state_r == ST_DONE);
  end

endmodule

// File: doc/rc4_prga_decoder.md
# rc4_prga_decoder

Parametrised RC4 keystream-generation-and-decrypt engine, the successor to the fixed 32-byte `decode` stage of the Lab 4 RC4 datapath. It runs after S-array initialisation and key scheduling, and it owns the S memory port while it runs. For each ciphertext byte it performs the RC4 PRGA swap, XORs the keystream byte with the ciphertext and writes the plaintext. It adds a configurable message length and a compile-time plaintext validity check, which allows early abort during brute-force key search.

## Interface
Parameters:
- `MSG_LEN`, default 32: number of message bytes; legal range is 1..256.
- `ADDR_W`, default `$clog2(MSG_LEN)` (minimum 1): address width of the encrypted and decrypted memories.

Ports:
- `clk`  in  1: the single system clock.
- `reset`  in  1: synchronous, active-high reset.
- `start`  in  1: level request; sampled only in IDLE.
- `s_mem_addr`  out  8: S memory address.
- `s_mem_data`  out  8: S memory write data.
- `s_mem_wren`  out  1: S memory write enable.
- `s_mem_q`  in  8: S memory read data.
- `encr_mem_addr`  out  ADDR_W: ciphertext ROM address.
- `encr_mem_q`  in  8: ciphertext ROM data.
- `decr_mem_addr`  out  ADDR_W: plaintext RAM address.
- `decr_mem_data`  out  8: plaintext RAM write data.
- `decr_mem_wren`  out  1: plaintext RAM write enable.
- `busy`  out  1: high in every state except IDLE and DONE.
- `done`  out  1: high while in DONE.
- `bad_key`  out  1: high in DONE if the run was aborted on an invalid character.

## Operation
- Registers:
  - `i`, `j`: 8 bits, arithmetic mod 256.
  - `k`: ADDR_W bits, the byte index.
  - `si`, `sj`, `f`, `enc`: 8 bits each.
- FSM states: IDLE, RD_I, WT_I, RD_J, WT_J, WR_I, WR_J, RD_F, WT_F, WR_O, NEXT, DONE.
- IDLE:
  - With `start`=1: clear `j`, `k` and `bad_key`, set `i`=1, go to RD_I.
  - Otherwise stay in IDLE.
- RD_I: `s_mem_addr`=`i`.
- WT_I: `si`<=`s_mem_q`, `j`<=`j`+`s_mem_q`.
- RD_J: `s_mem_addr`=`j`.
- WT_J: `sj`<=`s_mem_q`.
- WR_I: `s_mem_addr`=`i`, `s_mem_data`=`sj`, `s_mem_wren`=1.
- WR_J: `s_mem_addr`=`j`, `s_mem_data`=`si`, `s_mem_wren`=1. When `i`==`j` both writes store the same value, which is correct.
- RD_F: `s_mem_addr`=`si`+`sj` (mod 256) and `encr_mem_addr`=`k`.
- WT_F: `f`<=`s_mem_q`, `enc`<=`encr_mem_q`.
- WR_O: `decr_mem_addr`=`k`, `decr_mem_data`=`f`^`enc`, `decr_mem_wren`=1.
- NEXT:
  - If `k`==MSG_LEN-1, go to DONE.
  - Otherwise `k`<=`k`+1, `i`<=`i`+1 (wraps 255->0), go to RD_I.
- DONE: stay in DONE while `start`=1; when `start`=0, go to IDLE. A held `start` never re-triggers a run.
- In all states not listed above, every write enable is 0, and addresses and data are 0.

## Timing
- Memory contract: address, data and wren are sampled at the rising edge ending the cycle in which they are driven. `q` is valid from the next cycle and is captured at the end of the WT_* cycle.
- Memory outputs are Moore, decoded from state and registers. There is no combinational path from any input to any output.
- Each byte takes 10 cycles (RD_I..NEXT).
- Latency: take the edge at which IDLE sees `start`=1 as edge 0. DONE is entered at edge 10*MSG_LEN, and `done` is high from that edge.
- `reset` in any state: at the next edge go to IDLE, with all write enables 0, all registers 0 and `done`=`busy`=`bad_key`=0.
- Reset value of every output is 0.
- S memory contents are not restored on reset.

## Configuration
- Macro `RC4_PRGA_VALID_CHECK_EN`.
- With the macro defined, WR_O tests the plaintext byte `f`^`enc`:
  - The byte is valid if it lies in 8'h61..8'h7A or equals 8'h20.
  - On an invalid byte, the byte is still written, `bad_key`<=1 and the FSM goes WR_O->DONE, skipping NEXT. Remaining bytes are untouched.
- Without the macro, all MSG_LEN bytes are always processed and `bad_key` is tied to 0.

## Structure
- Package `rc4_pkg`:
  - state enum `rc4_prga_state_t`;
  - constants `RC4_CHAR_LO`=8'h61, `RC4_CHAR_HI`=8'h7A, `RC4_CHAR_SPACE`=8'h20;
  - `RC4_S_DEPTH`=256.
- Sub-module `rc4_char_check`: combinational, 8-bit in, 1-bit valid out. It is instantiated only under the macro.

## Test plan
- Reset: hold `reset` for 3 cycles with `start`=1. Required: all outputs 0 and the FSM in IDLE. Release reset: `busy`=1 at the next edge.
- Identity S (s[x]=x), `encr`[0]=8'h63, `encr`[1]=8'h64, MSG_LEN=32:
  - `decr`[0]=8'h61;
  - S afterwards has s[2]=3 and s[3]=2, and `decr`[1]=8'h61;
  - `done` rises at edge 320.
- Macro on, identity S, `encr`[0]=8'h00:
  - `decr`[0]=8'h02 is written;
  - `bad_key`=1 and `done`=1 at edge 9;
  - no write to `decr`[1].
- MSG_LEN=4, ADDR_W=2:
  - exactly 4 `decr_mem_wren` pulses, at addresses 0..3;
  - `done` at edge 40.
- `reset` asserted in WR_I of byte 5:
  - no S write occurs on the following cycle;
  - the FSM returns to IDLE;
  - the restart begins with `i`=1, `k`=0.
- `start` held high through DONE: no new run starts. Drop `start` for 1 cycle, then raise it: a second run begins with `k`=0.
